work_loader: RTL and testbench

Downstream stage of the memory manager: deserializes the 24-word job stream (8 midstate words, 16 header words) into `midState`/`headData`. It then sweeps the nonce through the hash core one request at a time and reports a winning nonce back to the memory manager over the `sol_claim`/`core_in` path. It sits between the memory manager's core interface and the SHA-256 double-hash core.

---
 rtl/work_loader_if.sv | 24 ++
 rtl/work_loader.sv | 140 ++++++++++++++
 tb/tb_work_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/work_loader_if.sv
// Handshake between work_loader (master) and the SHA-256 double-hash core (slave).
interface work_loader_if;
  logic        hash_go;
  logic [31:0] hash_nonce;
  logic        hash_ready;
  logic        hash_done;
  logic        hash_hit;

  modport master (
    output hash_go,
    output hash_nonce,
    input  hash_ready,
    input  hash_done,
    input  hash_hit
  );

  modport slave (
    input  hash_go,
    input  hash_nonce,
    output hash_ready,
    output hash_done,
    output hash_hit
  );
endinterface

// File: rtl/work_loader.sv
// Deserializes a 24-word job into midState/headData, then sweeps nonces through the hash core.
// Define WORK_LOADER_BSWAP_EN to byte-reverse each incoming job word before storage.
module work_loader #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_STEP  = 32'h0000_0001,
  parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_in,
  input  logic                shift_en,
  input  logic [31:0]         shift_data,
  output logic [255:0]        midState,
  output logic [511:0]        headData,
  work_loader_if.master       hash,
  output logic                sol_claim,
  output logic [31:0]         nonce_out,
  input  logic                sol_response,
  output logic                busy,
  output logic                exhausted
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    FOUND,
    EXHAUST
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  word_cnt;
  logic [31:0] nonce;
  logic [32:0] nonce_sum;
  logic        last_nonce;
  logic        go_req;
  logic [31:0] store_word;
  logic [3:0]  head_idx;

`ifdef WORK_LOADER_BSWAP_EN
  assign store_word = {shift_data[7:0], shift_data[15:8], shift_data[23:16], shift_data[31:24]};
`else
  assign store_word = shift_data;
`endif

  // Words 8..23 map to header slots 0..15; the 4-bit wrap of k-8 gives exactly that.
  assign head_idx   = word_cnt[3:0] - 4'd8;
  assign nonce_sum  = {1'b0, nonce} + {1'b0, NONCE_STEP};
  assign last_nonce = (nonce == NONCE_LIMIT) || nonce_sum[32];

  assign hash.hash_nonce = nonce;
  assign hash.hash_go    = reset & go_req;
  assign busy            = (state == LOAD) || (state == ISSUE) || (state == WAIT);

  always_comb begin
    state_next = state;
    go_req     = 1'b0;
    if (start_in) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        LOAD: begin
          if (shift_en && (word_cnt == 5'd23)) state_next = ISSUE;
        end
        ISSUE: begin
          if (hash.hash_ready) begin
            go_req     = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (hash.hash_done) begin
            if (hash.hash_hit)   state_next = FOUND;
            else if (last_nonce) state_next = EXHAUST;
            else                 state_next = ISSUE;
          end
        end
        FOUND: begin
          if (sol_response) state_next = IDLE;
        end
        EXHAUST: state_next = EXHAUST;
        default: state_next = IDLE;
      endcase
    end
  end

  // A new job clears the claim path but deliberately keeps the old job arrays visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      word_cnt  <= 5'd0;
      nonce     <= NONCE_START;
      midState  <= '0;
      headData  <= '0;
      sol_claim <= 1'b0;
      nonce_out <= 32'd0;
      exhausted <= 1'b0;
    end else begin
      state <= state_next;
      if (start_in) begin
        word_cnt  <= 5'd0;
        nonce     <= NONCE_START;
        sol_claim <= 1'b0;
        nonce_out <= 32'd0;
        exhausted <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (shift_en) begin
              if (word_cnt < 5'd8) midState[{word_cnt[2:0], 5'd0} +: 32] <= store_word;
              else                 headData[{head_idx, 5'd0} +: 32]      <= store_word;
              word_cnt <= word_cnt + 5'd1;
            end
          end
          WAIT: begin
            if (hash.hash_done) begin
              if (hash.hash_hit) begin
                nonce_out <= nonce;
                sol_claim <= 1'b1;
              end else if (last_nonce) begin
                exhausted <= 1'b1;
              end else begin
                nonce <= nonce_sum[31:0];
              end
            end
          end
          FOUND: begin
            if (sol_response) sol_claim <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_work_loader.sv
// Scoreboard bench for work_loader: a default-parameter instance plus a near-wrap instance
// (start FFFFFFFD, step 2) for the exhaustion case.
module tb_work_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_in = 1'b0;
  logic         start2 = 1'b0;
  logic         shift_en = 1'b0;
  logic [31:0]  shift_data = 32'd0;
  logic         sol_response = 1'b0;

  logic [255:0] mid, mid2;
  logic [511:0] head, head2;
  logic         sol_claim, sol_claim2;
  logic [31:0]  nonce_out, nonce_out2;
  logic         busy, busy2;
  logic         exhausted, exhausted2;

  work_loader_if hif();
  work_loader_if hif2();

  int n_checks = 0;
  int n_pass   = 0;
  int go_count = 0;
  int go2_count = 0;
  int cyc;
  int go_base;
  logic prev_claim = 1'b0;
  logic prev_claim2 = 1'b0;
  logic [31:0] exp_go[$];
  logic [31:0] exp_go2[$];
  logic [31:0] exp_claim[$];

`ifdef WORK_LOADER_BSWAP_EN
  localparam logic [31:0] BSWAP_EXP = 32'h4433_2211;
`else
  localparam logic [31:0] BSWAP_EXP = 32'h1122_3344;
`endif

  work_loader dut (
    .clk(clk), .reset(reset), .start_in(start_in), .shift_en(shift_en),
    .shift_data(shift_data), .midState(mid), .headData(head), .hash(hif.master),
    .sol_claim(sol_claim), .nonce_out(nonce_out), .sol_response(sol_response),
    .busy(busy), .exhausted(exhausted)
  );

  work_loader #(.NONCE_START(32'hFFFF_FFFD), .NONCE_STEP(32'h2)) dut2 (
    .clk(clk), .reset(reset), .start_in(start2), .shift_en(shift_en),
    .shift_data(shift_data), .midState(mid2), .headData(head2), .hash(hif2.master),
    .sol_claim(sol_claim2), .nonce_out(nonce_out2), .sol_response(sol_response),
    .busy(busy2), .exhausted(exhausted2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef WORK_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit second);
    if (second) start2 = 1'b1;
    else        start_in = 1'b1;
    step();
    start_in = 1'b0;
    start2   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int gap);
    shift_en   = 1'b1;
    shift_data = data;
    step();
    shift_en = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_go(input bit second, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 50) begin
      @(negedge clk);
      cycles++;
      seen = second ? hif2.hash_go : hif.hash_go;
    end
    if (!seen) checkOutput("go_timeout", 512'(seen), 512'(1));
    step();
  endtask

  // Scoreboard monitors: every request/claim is matched against the queued expectation.
  always @(negedge clk) begin
    if (hif.hash_go) begin
      go_count++;
      if (exp_go.size() == 0) checkOutput("go_unexpected", 512'(hif.hash_go), 512'(0));
      else checkOutput("go_nonce", 512'(hif.hash_nonce), 512'(exp_go.pop_front()));
    end
    if (sol_claim && !prev_claim) begin
      if (exp_claim.size() == 0) checkOutput("claim_unexpected", 512'(sol_claim), 512'(0));
      else checkOutput("claim_nonce", 512'(nonce_out), 512'(exp_claim.pop_front()));
    end
    prev_claim = sol_claim;
  end

  always @(negedge clk) begin
    if (hif2.hash_go) begin
      go2_count++;
      if (exp_go2.size() == 0) checkOutput("go2_unexpected", 512'(hif2.hash_go), 512'(0));
      else checkOutput("go2_nonce", 512'(hif2.hash_nonce), 512'(exp_go2.pop_front()));
    end
    if (sol_claim2 && !prev_claim2) checkOutput("claim2_unexpected", 512'(sol_claim2), 512'(0));
    prev_claim2 = sol_claim2;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hif.hash_ready  = 1'b1;
    hif.hash_done   = 1'b0;
    hif.hash_hit    = 1'b0;
    hif2.hash_ready = 1'b1;
    hif2.hash_done  = 1'b0;
    hif2.hash_hit   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid", 512'(mid), 512'(0));
    checkOutput("rst_head", head, 512'(0));
    checkOutput("rst_go", 512'(hif.hash_go), 512'(0));
    checkOutput("rst_claim", 512'(sol_claim), 512'(0));
    checkOutput("rst_nonce_out", 512'(nonce_out), 512'(0));
    checkOutput("rst_exhausted", 512'(exhausted), 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(0));
    checkOutput("rst_hash_nonce", 512'(hif.hash_nonce), 512'(0));
    checkOutput("rst_hash_nonce2", 512'(hif2.hash_nonce), 512'(32'hFFFF_FFFD));
    step();
    reset = 1'b1;
    step();

    $display("[TB] contiguous load, miss 0..4, hit 5");
    go_base = go_count;
    pulse_start(1'b0);
    exp_go.push_back(32'd0);
    for (int k = 0; k < 24; k++) applyStimulus(32'(k), 0);
    wait_go(1'b0, cyc);
    checkOutput("go_latency_load", 512'(cyc), 512'(1));
    checkOutput("mid_w0", 512'(mid[31:0]), 512'(stored(32'd0)));
    checkOutput("mid_w7", 512'(mid[255:224]), 512'(stored(32'd7)));
    checkOutput("head_w8", 512'(head[31:0]), 512'(stored(32'd8)));
    checkOutput("head_w23", 512'(head[511:480]), 512'(stored(32'd23)));
    for (int n = 0; n < 6; n++) begin
      step();
      hif.hash_done = 1'b1;
      hif.hash_hit  = (n == 5);
      if (n < 5) exp_go.push_back(32'(n + 1));
      else       exp_claim.push_back(32'd5);
      if (n == 1) begin
        hif.hash_ready = 1'b0;
        fork
          begin
            repeat (4) @(posedge clk);
            #1 hif.hash_ready = 1'b1;
          end
        join_none
      end
      step();
      hif.hash_done = 1'b0;
      hif.hash_hit  = 1'b0;
      if (n < 5) begin
        wait_go(1'b0, cyc);
        checkOutput("go_latency_miss", 512'(cyc), 512'((n == 1) ? 4 : 1));
      end
    end
    @(negedge clk);
    checkOutput("claim_up", 512'(sol_claim), 512'(1));
    checkOutput("claim_nonce_out", 512'(nonce_out), 512'(5));
    step();
    @(negedge clk);
    checkOutput("claim_held", 512'(sol_claim), 512'(1));
    step();
    sol_response = 1'b1;
    step();
    sol_response = 1'b0;
    @(negedge clk);
    checkOutput("claim_cleared", 512'(sol_claim), 512'(0));
    checkOutput("nonce_out_kept", 512'(nonce_out), 512'(5));
    checkOutput("idle_busy", 512'(busy), 512'(0));
    checkOutput("go_pulses", 512'(go_count - go_base), 512'(6));

    $display("[TB] gapped load restarted by start_in");
    step();
    pulse_start(1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(32'(100 + k), 2);
    start_in   = 1'b1;
    shift_en   = 1'b1;
    shift_data = 32'hDEAD_BEEF;
    step();
    start_in = 1'b0;
    shift_en = 1'b0;
    exp_go.push_back(32'd0);
    for (int k = 0; k < 24; k++) applyStimulus(32'(200 + k), 0);
    wait_go(1'b0, cyc);
    checkOutput("restart_go_latency", 512'(cyc), 512'(1));
    checkOutput("restart_mid_w0", 512'(mid[31:0]), 512'(stored(32'd200)));
    checkOutput("restart_mid_w1", 512'(mid[63:32]), 512'(stored(32'd201)));
    checkOutput("restart_mid_w7", 512'(mid[255:224]), 512'(stored(32'd207)));
    checkOutput("restart_head_w8", 512'(head[31:0]), 512'(stored(32'd208)));
    checkOutput("restart_head_w23", 512'(head[511:480]), 512'(stored(32'd223)));

    $display("[TB] reset during WAIT then stale hit");
    reset = 1'b0;
    step();
    reset = 1'b1;
    hif.hash_done = 1'b1;
    hif.hash_hit  = 1'b1;
    step();
    hif.hash_done = 1'b0;
    hif.hash_hit  = 1'b0;
    @(negedge clk);
    checkOutput("abort_mid", 512'(mid), 512'(0));
    checkOutput("abort_head", head, 512'(0));
    checkOutput("abort_claim", 512'(sol_claim), 512'(0));
    checkOutput("abort_nonce_out", 512'(nonce_out), 512'(0));
    checkOutput("abort_busy", 512'(busy), 512'(0));
    checkOutput("abort_exhausted", 512'(exhausted), 512'(0));
    step();
    @(negedge clk);
    checkOutput("abort_claim_later", 512'(sol_claim), 512'(0));

    $display("[TB] word order and start beating hash_done");
    step();
    pulse_start(1'b0);
    exp_go.push_back(32'd0);
    applyStimulus(32'h1122_3344, 0);
    for (int k = 1; k < 24; k++) applyStimulus(32'(k), 0);
    wait_go(1'b0, cyc);
    checkOutput("word_order_w0", 512'(mid[31:0]), 512'(BSWAP_EXP));
    step();
    start_in      = 1'b1;
    hif.hash_done = 1'b1;
    hif.hash_hit  = 1'b1;
    step();
    start_in      = 1'b0;
    hif.hash_done = 1'b0;
    hif.hash_hit  = 1'b0;
    @(negedge clk);
    checkOutput("start_wins_claim", 512'(sol_claim), 512'(0));
    checkOutput("start_wins_busy", 512'(busy), 512'(1));
    checkOutput("start_wins_nonce_out", 512'(nonce_out), 512'(0));
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    $display("[TB] near-wrap sweep exhausts");
    pulse_start(1'b1);
    exp_go2.push_back(32'hFFFF_FFFD);
    for (int k = 0; k < 24; k++) applyStimulus(32'(300 + k), 0);
    wait_go(1'b1, cyc);
    checkOutput("wrap_go_latency", 512'(cyc), 512'(1));
    checkOutput("idle_ignores_shift", 512'(mid), 512'(0));
    step();
    hif2.hash_done = 1'b1;
    exp_go2.push_back(32'hFFFF_FFFF);
    step();
    hif2.hash_done = 1'b0;
    wait_go(1'b1, cyc);
    checkOutput("wrap_go_latency2", 512'(cyc), 512'(1));
    step();
    hif2.hash_done = 1'b1;
    step();
    hif2.hash_done = 1'b0;
    @(negedge clk);
    checkOutput("exhausted_set", 512'(exhausted2), 512'(1));
    checkOutput("exhausted_busy", 512'(busy2), 512'(0));
    repeat (10) step();
    checkOutput("exhausted_held", 512'(exhausted2), 512'(1));
    checkOutput("wrap_go_pulses", 512'(go2_count), 512'(2));

    step();
    checkOutput("go_queue_drained", 512'(exp_go.size()), 512'(0));
    checkOutput("go2_queue_drained", 512'(exp_go2.size()), 512'(0));
    checkOutput("claim_queue_drained", 512'(exp_claim.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
